hazard_unit_mc: RTL and testbench
=================================

// Module: hazard_unit_mc
// PURPOSE
//  Parametrised hazard/forwarding unit for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Generates ID- and EX-stage forward selects for NREAD source operands, plus PC/IF-ID stall and ID-EX flush.
//  Stalls cover three cases: load-use, branch-compare-in-ID and multi-cycle MULT/DIV (HI/LO) busy.
//  Holds the MDU busy counter and a stall-cycle performance counter. Sits beside the pipeline registers in the CPU top.
// PARAMETERS
//  NREAD    2   source operands per instruction (rs,rt,...); operand i at bits [i*AW +: AW]
//  AW       5   register address width; address 0 is hardwired zero
//  MUL_CYC  5   cycles MDU busy after a MULT/MULTU start (1..255)
//  DIV_CYC  10  cycles MDU busy after a DIV/DIVU start (1..255)
//  PCW      32  stall performance counter width
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous reset, active low
//  src_d        in   NREAD*AW source reg addrs of instruction in ID
//  src_vld_d    in   NREAD    bit i = operand i actually read in ID
//  src_e        in   NREAD*AW source reg addrs of instruction in EX
//  regaddr_e/m/w in  AW       destination reg addr in EX/MEM/WB
//  regwrite_e/m/w in 1        destination write enable in EX/MEM/WB
//  memtoreg_e   in   1        EX instr is a load
//  memtoreg_m   in   1        MEM instr is a load
//  branch_d     in   1        ID instr compares operands in ID (beq/bne/jr...)
//  mdu_use_d    in   1        ID instr reads/writes HI/LO or starts MDU
//  mdu_start_e  in   1        EX instr starts MDU this cycle
//  mdu_div_e    in   1        with mdu_start_e: 1=divide, 0=multiply
//  fwd_d        out  2*NREAD  ID forward sel per operand: 00 regfile,01 MEM,10 WB
//  fwd_e        out  2*NREAD  EX forward sel per operand: 00 ID/EX reg,01 MEM,10 WB
//  stall_pc     out  1        hold PC
//  stall_if_id  out  1        hold IF/ID register
//  flush_id_ex  out  1        insert bubble into ID/EX
//  mdu_busy     out  1        MDU counter non-zero
//  mdu_err      out  1        sticky: mdu_start_e seen while mdu_busy
//  stall_cnt    out  PCW      cycles with stall_pc=1, saturating
// BEHAVIOUR
//  Forwarding (combinational, per operand i, same for D and E):
//   - addr==0 -> 00; else regwrite_m && addr==regaddr_m -> 01; else regwrite_w && addr==regaddr_w -> 10; else 00.
//   - MEM has priority over WB.
//  Match for stall terms = src_vld_d[i] && src_d[i]!=0 && src_d[i]==X, for any i.
//   - load_use = memtoreg_e && regwrite_e && match(regaddr_e).
//   - br_haz = branch_d && ((regwrite_e && match(regaddr_e)) || (memtoreg_m && regwrite_m && match(regaddr_m))).
//   - mdu_haz = mdu_use_d && (mdu_busy || mdu_start_e).
//   - stall = load_use|br_haz|mdu_haz; stall_pc=stall_if_id=flush_id_ex=stall (same cycle, combinational).
//  MDU counter cnt (8 bit):
//   - mdu_start_e && cnt==0 -> cnt <= mdu_div_e ? DIV_CYC : MUL_CYC.
//   - Else if cnt!=0 -> cnt <= cnt-1. mdu_busy = (cnt!=0).
//   - mdu_start_e && cnt!=0 -> start ignored, cnt keeps decrementing, mdu_err <= 1 until reset.
//  stall_cnt:
//   - +1 each cycle stall_pc=1; holds at 2^PCW-1 (no wrap).
//  Reset (rst_n=0 at clk edge):
//   - cnt=0, mdu_busy=0, mdu_err=0, stall_cnt=0.
//   - While rst_n=0, fwd_d=fwd_e=0 and stall/flush outputs=0 regardless of inputs.
//   - Reset mid-divide abandons the operation; mdu_busy low the cycle after the reset edge.
//  Simultaneous: load_use and mdu_haz together -> a single stall; stall_cnt increments once.
// TESTING
//  - T1: regwrite_m=1,regaddr_m=8; regwrite_w=1,regaddr_w=8; src_e[0]=8 -> fwd_e[1:0]=01; drop regwrite_m -> 10.
//  - T2: src_e[0]=0 with regwrite_m=1,regaddr_m=0 -> fwd_e[1:0]=00.
//  - T3: load in EX (memtoreg_e=1,regaddr_e=9), src_d[1]=9, src_vld_d[1]=1 -> stall/flush=1.
//    Same with src_vld_d[1]=0 -> stall=0.
//  - T4: branch_d=1, src_d[0]=4, regwrite_e=1,regaddr_e=4 -> stall=1 for one cycle.
//    Next cycle the instr is in MEM (non-load) -> stall=0, fwd_d[1:0]=01.
//  - T5: mdu_start_e,mdu_div_e=1 (DIV_CYC=10) -> mdu_busy high exactly 10 cycles.
//    mdu_use_d=1 throughout -> stall high on the start cycle + 10 cycles; stall_cnt=11.
//  - T6: start MULT, second start 2 cycles later -> mdu_err=1, busy ends at original time.
//    rst_n=0 mid-operation -> busy=0, err=0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/hazard_unit_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_mc_if
//  Brief    : Pipeline <-> hazard unit signal bundle (operands, dests, selects)
//  Revision : 1.0
// ============================================================================
interface hazard_unit_mc_if #(
    parameter int NREAD = 2,
    parameter int AW    = 5,
    parameter int PCW   = 32
);
    logic [NREAD*AW-1:0] src_d;
    logic [NREAD-1:0]    src_vld_d;
    logic [NREAD*AW-1:0] src_e;
    logic [AW-1:0]       regaddr_e;
    logic [AW-1:0]       regaddr_m;
    logic [AW-1:0]       regaddr_w;
    logic                regwrite_e;
    logic                regwrite_m;
    logic                regwrite_w;
    logic                memtoreg_e;
    logic                memtoreg_m;
    logic                branch_d;
    logic                mdu_use_d;
    logic                mdu_start_e;
    logic                mdu_div_e;
    logic [2*NREAD-1:0]  fwd_d;
    logic [2*NREAD-1:0]  fwd_e;
    logic                stall_pc;
    logic                stall_if_id;
    logic                flush_id_ex;
    logic                mdu_busy;
    logic                mdu_err;
    logic [PCW-1:0]      stall_cnt;

    modport master (
        output src_d, src_vld_d, src_e, regaddr_e, regaddr_m, regaddr_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
               branch_d, mdu_use_d, mdu_start_e, mdu_div_e,
        input  fwd_d, fwd_e, stall_pc, stall_if_id, flush_id_ex,
               mdu_busy, mdu_err, stall_cnt
    );

    modport slave (
        input  src_d, src_vld_d, src_e, regaddr_e, regaddr_m, regaddr_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
               branch_d, mdu_use_d, mdu_start_e, mdu_div_e,
        output fwd_d, fwd_e, stall_pc, stall_if_id, flush_id_ex,
               mdu_busy, mdu_err, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_mc
//  Brief    : 5-stage MIPS forwarding selects, load/branch/MDU stalls, counters
//  Revision : 1.0
// ============================================================================
module hazard_unit_mc #(
    parameter int NREAD   = 2,
    parameter int AW      = 5,
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10,
    parameter int PCW     = 32
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_unit_mc_if.slave    hif
);
    localparam logic [7:0] c_mul_cyc = 8'(MUL_CYC);
    localparam logic [7:0] c_div_cyc = 8'(DIV_CYC);

    logic [2*NREAD-1:0] w_fwd_d;
    logic [2*NREAD-1:0] w_fwd_e;
    logic [NREAD-1:0]   w_match_e;
    logic [NREAD-1:0]   w_match_m;
    logic               w_load_use;
    logic               w_br_haz;
    logic               w_mdu_haz;
    logic               w_stall;
    logic [7:0]         r_cnt;
    logic               r_err;
    logic [PCW-1:0]     r_stall_cnt;

    // MEM beats WB; register 0 is never forwarded
    for (genvar i = 0; i < NREAD; i++) begin : g_op
        logic [AW-1:0] w_sd;
        logic [AW-1:0] w_se;
        assign w_sd = hif.src_d[i*AW +: AW];
        assign w_se = hif.src_e[i*AW +: AW];

        assign w_fwd_d[2*i +: 2] =
            (w_sd == '0)                                  ? 2'b00 :
            (hif.regwrite_m && (w_sd == hif.regaddr_m))   ? 2'b01 :
            (hif.regwrite_w && (w_sd == hif.regaddr_w))   ? 2'b10 : 2'b00;
        assign w_fwd_e[2*i +: 2] =
            (w_se == '0)                                  ? 2'b00 :
            (hif.regwrite_m && (w_se == hif.regaddr_m))   ? 2'b01 :
            (hif.regwrite_w && (w_se == hif.regaddr_w))   ? 2'b10 : 2'b00;

        assign w_match_e[i] = hif.src_vld_d[i] && (w_sd != '0) && (w_sd == hif.regaddr_e);
        assign w_match_m[i] = hif.src_vld_d[i] && (w_sd != '0) && (w_sd == hif.regaddr_m);
    end

    assign w_load_use = hif.memtoreg_e && hif.regwrite_e && (|w_match_e);
    assign w_br_haz   = hif.branch_d &&
                        ((hif.regwrite_e && (|w_match_e)) ||
                         (hif.memtoreg_m && hif.regwrite_m && (|w_match_m)));
    assign w_mdu_haz  = hif.mdu_use_d && ((r_cnt != 8'd0) || hif.mdu_start_e);

    // Everything combinational is forced quiet while reset is held
    assign w_stall         = rst_n && (w_load_use || w_br_haz || w_mdu_haz);
    assign hif.fwd_d       = rst_n ? w_fwd_d : '0;
    assign hif.fwd_e       = rst_n ? w_fwd_e : '0;
    assign hif.stall_pc    = w_stall;
    assign hif.stall_if_id = w_stall;
    assign hif.flush_id_ex = w_stall;
    assign hif.mdu_busy    = (r_cnt != 8'd0);
    assign hif.mdu_err     = r_err;
    assign hif.stall_cnt   = r_stall_cnt;

    // A start while busy is dropped; the running operation keeps its timing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if (hif.mdu_start_e && (r_cnt == 8'd0))
                r_cnt <= hif.mdu_div_e ? c_div_cyc : c_mul_cyc;
            else if (r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
            if (hif.mdu_start_e && (r_cnt != 8'd0))
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_stall && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + PCW'(1);
    end
endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit_mc
//  Brief    : Directed self-checking bench for hazard_unit_mc (PCW=4 for saturation)
//  Revision : 1.0
// ============================================================================
module tb_hazard_unit_mc;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hazard_unit_mc_if #(.NREAD(2), .AW(5), .PCW(4)) hif ();

    hazard_unit_mc #(
        .NREAD(2), .AW(5), .MUL_CYC(5), .DIV_CYC(10), .PCW(4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.src_d = '0; hif.src_vld_d = '0; hif.src_e = '0;
        hif.regaddr_e = '0; hif.regaddr_m = '0; hif.regaddr_w = '0;
        hif.regwrite_e = 1'b0; hif.regwrite_m = 1'b0; hif.regwrite_w = 1'b0;
        hif.memtoreg_e = 1'b0; hif.memtoreg_m = 1'b0; hif.branch_d = 1'b0;
        hif.mdu_use_d = 1'b0; hif.mdu_start_e = 1'b0; hif.mdu_div_e = 1'b0;
    endtask

    // Advance one edge and settle 1ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        rst_n = 1'b0;
        // Hazardous inputs during reset must not show through
        hif.regwrite_m = 1'b1; hif.regaddr_m = 5'd8; hif.src_e = {5'd0, 5'd8};
        hif.memtoreg_e = 1'b1; hif.regwrite_e = 1'b1; hif.regaddr_e = 5'd9;
        hif.src_d = {5'd9, 5'd0}; hif.src_vld_d = 2'b10;
        step();
        step();
        check("rst_fwd_e", 32'(hif.fwd_e), 32'h0);
        check("rst_stall", 32'(hif.stall_pc), 32'h0);
        check("rst_busy", 32'(hif.mdu_busy), 32'h0);
        check("rst_err", 32'(hif.mdu_err), 32'h0);
        check("rst_cnt", 32'(hif.stall_cnt), 32'h0);
        clear_inputs();
        rst_n = 1'b1;
        step();

        // T1: MEM over WB, then WB alone
        hif.regwrite_m = 1'b1; hif.regaddr_m = 5'd8;
        hif.regwrite_w = 1'b1; hif.regaddr_w = 5'd8;
        hif.src_e = {5'd0, 5'd8};
        #1 check("t1_fwd_mem", 32'(hif.fwd_e), 32'h1);
        hif.regwrite_m = 1'b0;
        #1 check("t1_fwd_wb", 32'(hif.fwd_e), 32'h2);
        hif.src_e = {5'd8, 5'd8}; hif.src_d = {5'd8, 5'd0};
        #1 check("t1_fwd_e_both", 32'(hif.fwd_e), 32'hA);
        check("t1_fwd_d_op1", 32'(hif.fwd_d), 32'h8);

        // T2: register 0 never forwarded
        hif.src_e = '0; hif.src_d = '0;
        hif.regwrite_m = 1'b1; hif.regaddr_m = 5'd0;
        hif.regwrite_w = 1'b1; hif.regaddr_w = 5'd0;
        #1 check("t2_fwd_zero", 32'(hif.fwd_e), 32'h0);
        check("t2_no_stall", 32'(hif.stall_pc), 32'h0);

        // T3: load-use on operand 1, then operand not actually read
        clear_inputs();
        hif.memtoreg_e = 1'b1; hif.regwrite_e = 1'b1; hif.regaddr_e = 5'd9;
        hif.src_d = {5'd9, 5'd0}; hif.src_vld_d = 2'b10;
        #1 check("t3_stall_pc", 32'(hif.stall_pc), 32'h1);
        check("t3_stall_ifid", 32'(hif.stall_if_id), 32'h1);
        check("t3_flush", 32'(hif.flush_id_ex), 32'h1);
        hif.src_vld_d = 2'b01;
        #1 check("t3_not_read", 32'(hif.stall_pc), 32'h0);

        // T4: branch needs an ALU result still in EX
        clear_inputs();
        hif.branch_d = 1'b1; hif.src_d = {5'd0, 5'd4}; hif.src_vld_d = 2'b01;
        hif.regwrite_e = 1'b1; hif.regaddr_e = 5'd4;
        #1 check("t4_br_ex", 32'(hif.stall_pc), 32'h1);
        step();
        hif.regwrite_e = 1'b0; hif.regaddr_e = 5'd0;
        hif.regwrite_m = 1'b1; hif.regaddr_m = 5'd4;
        #1 check("t4_br_mem", 32'(hif.stall_pc), 32'h0);
        check("t4_fwd_d", 32'(hif.fwd_d), 32'h1);
        hif.memtoreg_m = 1'b1;
        #1 check("t4_br_load_mem", 32'(hif.stall_pc), 32'h1);
        hif.memtoreg_m = 1'b0; hif.branch_d = 1'b0;
        hif.regwrite_m = 1'b0; hif.regwrite_e = 1'b1; hif.regaddr_e = 5'd4;
        #1 check("t4_nobranch", 32'(hif.stall_pc), 32'h0);

        // T5: divide with dependent MDU use, coincident with a load-use
        clear_inputs();
        do_reset();
        hif.mdu_start_e = 1'b1; hif.mdu_div_e = 1'b1; hif.mdu_use_d = 1'b1;
        hif.memtoreg_e = 1'b1; hif.regwrite_e = 1'b1; hif.regaddr_e = 5'd9;
        hif.src_d = {5'd9, 5'd0}; hif.src_vld_d = 2'b10;
        #1 check("t5_start_stall", 32'(hif.stall_pc), 32'h1);
        check("t5_start_busy", 32'(hif.mdu_busy), 32'h0);
        step();
        hif.mdu_start_e = 1'b0; hif.mdu_div_e = 1'b0;
        hif.memtoreg_e = 1'b0; hif.regwrite_e = 1'b0; hif.src_d = '0; hif.src_vld_d = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("t5_busy_%0d", k), 32'(hif.mdu_busy), 32'h1);
            check($sformatf("t5_stall_%0d", k), 32'(hif.stall_pc), 32'h1);
            step();
        end
        check("t5_busy_end", 32'(hif.mdu_busy), 32'h0);
        check("t5_stall_end", 32'(hif.stall_pc), 32'h0);
        check("t5_stall_cnt", 32'(hif.stall_cnt), 32'd11);
        check("t5_err", 32'(hif.mdu_err), 32'h0);

        // Saturation: 6 more stall cycles from 11 must hold at 15
        hif.mdu_use_d = 1'b0;
        hif.memtoreg_e = 1'b1; hif.regwrite_e = 1'b1; hif.regaddr_e = 5'd3;
        hif.src_d = {5'd0, 5'd3}; hif.src_vld_d = 2'b01;
        for (int k = 0; k < 6; k++) step();
        check("sat_cnt", 32'(hif.stall_cnt), 32'd15);
        clear_inputs();

        // T6: overlapping MULT start flags error, original timing kept
        hif.mdu_start_e = 1'b1;
        step();
        hif.mdu_start_e = 1'b0;
        check("t6_busy0", 32'(hif.mdu_busy), 32'h1);
        step();
        hif.mdu_start_e = 1'b1;
        step();
        hif.mdu_start_e = 1'b0;
        check("t6_err", 32'(hif.mdu_err), 32'h1);
        check("t6_busy3", 32'(hif.mdu_busy), 32'h1);
        step();
        check("t6_busy2", 32'(hif.mdu_busy), 32'h1);
        step();
        check("t6_busy1", 32'(hif.mdu_busy), 32'h1);
        step();
        check("t6_busy_end", 32'(hif.mdu_busy), 32'h0);
        check("t6_err_sticky", 32'(hif.mdu_err), 32'h1);

        // Reset mid-multiply
        hif.mdu_start_e = 1'b1; hif.mdu_use_d = 1'b1;
        step();
        hif.mdu_start_e = 1'b0;
        check("t6_cnt_held", 32'(hif.stall_cnt), 32'd15);
        rst_n = 1'b0;
        hif.regwrite_m = 1'b1; hif.regaddr_m = 5'd6; hif.src_d = {5'd0, 5'd6};
        #1 check("t6_rst_stall", 32'(hif.stall_pc), 32'h0);
        check("t6_rst_fwd_d", 32'(hif.fwd_d), 32'h0);
        step();
        check("t6_rst_busy", 32'(hif.mdu_busy), 32'h0);
        check("t6_rst_err", 32'(hif.mdu_err), 32'h0);
        check("t6_rst_cnt", 32'(hif.stall_cnt), 32'h0);
        rst_n = 1'b1;
        clear_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
